// File: rtl/riscv_alu_pkg.sv
// Shared definitions for the riscv_alu block and its built-in self-test:
// ALU opcode encoding, the self-test vector record and the vector count.
package riscv_alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_AND  = 4'h2,
        ALU_OR   = 4'h3,
        ALU_XOR  = 4'h4,
        ALU_SLL  = 4'h5,
        ALU_SRL  = 4'h6,
        ALU_SRA  = 4'h7,
        ALU_SLT  = 4'h8,
        ALU_SLTU = 4'h9,
        ALU_MUL  = 4'hA,
        ALU_MAC  = 4'hB
    } alu_op_e;

    typedef struct packed {
        alu_op_e     op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expected;
        logic        ovf_exp;
        logic        ovf_care;
    } alu_vec_t;

    localparam int unsigned ALU_BIST_NUM_VEC = 21;

    function automatic alu_vec_t mk_vec(input alu_op_e     op,
                                        input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic [31:0] expected,
                                        input logic        ovf_exp,
                                        input logic        ovf_care);
        alu_vec_t v;
        v.op       = op;
        v.a        = a;
        v.b        = b;
        v.expected = expected;
        v.ovf_exp  = ovf_exp;
        v.ovf_care = ovf_care;
        return v;
    endfunction

endpackage

// File: rtl/riscv_alu_bist_rom.sv
// Fixed self-test vector table for riscv_alu, indexed combinationally.
module riscv_alu_bist_rom
    import riscv_alu_pkg::*;
(
    input  logic [4:0] idx,
    output alu_vec_t   vec
);

    // Table lookup; out-of-range indices return an all-zero ADD vector.
    always_comb begin
        vec = '0;
        case (idx)
            5'd0:  vec = mk_vec(ALU_ADD,  32'h00000005, 32'h00000003, 32'h00000008, 1'b0, 1'b1);
            5'd1:  vec = mk_vec(ALU_ADD,  32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 1'b1);
            5'd2:  vec = mk_vec(ALU_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b1);
            5'd3:  vec = mk_vec(ALU_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1, 1'b1);
            5'd4:  vec = mk_vec(ALU_SUB,  32'h00000008, 32'h00000003, 32'h00000005, 1'b0, 1'b1);
            5'd5:  vec = mk_vec(ALU_SUB,  32'h00000005, 32'h00000005, 32'h00000000, 1'b0, 1'b1);
            5'd6:  vec = mk_vec(ALU_SUB,  32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b1);
            5'd7:  vec = mk_vec(ALU_AND,  32'hFF00FF00, 32'h0F0F0F0F, 32'h0F000F00, 1'b0, 1'b0);
            5'd8:  vec = mk_vec(ALU_OR,   32'hFF00FF00, 32'h0F0F0F0F, 32'hFF0FFF0F, 1'b0, 1'b0);
            5'd9:  vec = mk_vec(ALU_XOR,  32'hFFFFFFFF, 32'hAAAAAAAA, 32'h55555555, 1'b0, 1'b0);
            5'd10: vec = mk_vec(ALU_SLL,  32'h00000001, 32'h00000001, 32'h00000002, 1'b0, 1'b0);
            5'd11: vec = mk_vec(ALU_SLL,  32'h0000000F, 32'h00000004, 32'h000000F0, 1'b0, 1'b0);
            5'd12: vec = mk_vec(ALU_SRL,  32'h80000000, 32'h00000001, 32'h40000000, 1'b0, 1'b0);
            5'd13: vec = mk_vec(ALU_SRA,  32'hF0000000, 32'h00000004, 32'hFF000000, 1'b0, 1'b0);
            5'd14: vec = mk_vec(ALU_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0);
            5'd15: vec = mk_vec(ALU_SLT,  32'h00000005, 32'h00000003, 32'h00000000, 1'b0, 1'b0);
            5'd16: vec = mk_vec(ALU_SLTU, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);
            5'd17: vec = mk_vec(ALU_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b0);
            5'd18: vec = mk_vec(ALU_MUL,  32'h00000003, 32'h00000004, 32'h0000000C, 1'b0, 1'b0);
            5'd19: vec = mk_vec(ALU_MUL,  32'h12345678, 32'h00000000, 32'h00000000, 1'b0, 1'b0);
            5'd20: vec = mk_vec(ALU_MUL,  32'hABCDEF01, 32'h00000001, 32'hABCDEF01, 1'b0, 1'b0);
            default: vec = mk_vec(ALU_ADD, '0, '0, '0, 1'b0, 1'b0);
        endcase
    end

endmodule

// File: rtl/riscv_alu_bist.sv
// Built-in self-test controller for riscv_alu. Issues the fixed vector table
// one request at a time, waits (bounded) for each result and accumulates
// pass/fail statistics. Optional macro ALU_BIST_FLAG_CHECK_EN additionally
// checks the zero and overflow flags returned by the ALU.
module riscv_alu_bist
    import riscv_alu_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [7:0]       pass_count,
    output logic [7:0]       fail_count,
    output logic [7:0]       first_fail_idx,
    output logic             timeout_err,
    output logic             alu_valid_in,
    output logic [3:0]       alu_op,
    output logic [WIDTH-1:0] alu_operand_a,
    output logic [WIDTH-1:0] alu_operand_b,
    input  logic             alu_valid_out,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_overflow,
    input  logic             alu_zero
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_e;

    state_e     state;
    state_e     state_next;
    logic [4:0] idx;
    logic [7:0] wait_cnt;
    logic       vec_ok;
    logic       resp_ok;
    logic       last_vec;
    logic       wait_expired;
    alu_vec_t   vec;

    riscv_alu_bist_rom u_rom (
        .idx (idx),
        .vec (vec)
    );

    assign last_vec     = (idx == 5'(ALU_BIST_NUM_VEC - 1));
    assign wait_expired = (wait_cnt == 8'(TIMEOUT - 1));

    // Strict 4-state compare so an X/Z result can never be scored as a pass.
`ifdef ALU_BIST_FLAG_CHECK_EN
    assign resp_ok = (alu_result === WIDTH'(vec.expected))
                  && (alu_zero === (vec.expected == '0))
                  && (!vec.ovf_care || (alu_overflow === vec.ovf_exp));
`else
    logic unused_flags;
    assign unused_flags = ^{alu_zero, alu_overflow, vec.ovf_exp, vec.ovf_care};
    assign resp_ok = (alu_result === WIDTH'(vec.expected));
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // Next-state logic; start is only honoured in IDLE and DONE.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE: if (start) state_next = S_ISSUE;
            S_ISSUE:        state_next = S_WAIT;
            S_WAIT:         if (alu_valid_out || wait_expired) state_next = S_CHECK;
            S_CHECK:        state_next = last_vec ? S_DONE : S_ISSUE;
            default:        state_next = S_IDLE;
        endcase
    end

    // Status and ALU request outputs; request fields are zero unless issuing.
    always_comb begin
        busy          = 1'b0;
        done          = 1'b0;
        alu_valid_in  = 1'b0;
        alu_op        = '0;
        alu_operand_a = '0;
        alu_operand_b = '0;
        case (state)
            S_ISSUE: begin
                busy          = 1'b1;
                alu_valid_in  = 1'b1;
                alu_op        = vec.op;
                alu_operand_a = WIDTH'(vec.a);
                alu_operand_b = WIDTH'(vec.b);
            end
            S_WAIT, S_CHECK: busy = 1'b1;
            S_DONE:          done = 1'b1;
            default: ;
        endcase
    end

    assign pass = done && (fail_count == '0);

    // Vector index, wait timer, result capture and saturating statistics.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx            <= '0;
            wait_cnt       <= '0;
            vec_ok         <= 1'b0;
            pass_count     <= '0;
            fail_count     <= '0;
            first_fail_idx <= '1;
            timeout_err    <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        idx            <= '0;
                        pass_count     <= '0;
                        fail_count     <= '0;
                        first_fail_idx <= '1;
                        timeout_err    <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    wait_cnt <= '0;
                    vec_ok   <= 1'b0;
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt + 8'd1;
                    if (alu_valid_out) begin
                        vec_ok <= resp_ok;
                    end else if (wait_expired) begin
                        vec_ok      <= 1'b0;
                        timeout_err <= 1'b1;
                    end
                end
                S_CHECK: begin
                    if (vec_ok) begin
                        if (pass_count != '1) pass_count <= pass_count + 8'd1;
                    end else begin
                        if (fail_count != '1) fail_count <= fail_count + 8'd1;
                        if (first_fail_idx == '1) first_fail_idx <= 8'(idx);
                    end
                    if (!last_vec) idx <= idx + 5'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
